mux_cfg_loader: RTL and testbench
=================================

Name: mux_cfg_loader

Overview:
- Configuration sequencer for the two-level transmission-gate routing muxes. Each mux has a first level of L1_SIZE gates and a second level of L2_SIZE gates.
- Accepts one binary select index per mux over a valid/ready stream.
- Encodes each index into the two one-hot mem fields the mux needs.
- Serially shifts the full frame into the configuration flip-flop chain via ccff_head/ccff_en. The chain cells produce mem_inv locally; this block never drives it.

Parameters:
- NUM_MUX, 4, number of muxes on the chain segment.
- L1_SIZE, 3, first-level inputs per mux (one-hot mem field width).
- L2_SIZE, 4, second-level inputs per mux (one-hot mem field width).
- Derived, not overridable:
  - MEM_BITS = L1_SIZE+L2_SIZE (default 7).
  - TOTAL = NUM_MUX*MEM_BITS (default 28).
  - SEL_W = clog2(L1_SIZE*L2_SIZE) (default 4).

Ports:
- prog_clk  in  1  programming clock; all logic on its rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- sel_valid  in  1  select beat valid.
- sel_ready  out  1  block can accept a select beat.
- sel_data  in  SEL_W  select index for the next mux, mux 0 first.
- ccff_head  out  1  serial config bit into the chain.
- ccff_en  out  1  chain shift enable; chain shifts on prog_clk when high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame is fully shifted.
- err_range  out  1  sticky: some sel_data >= L1_SIZE*L2_SIZE during the current load.

Behaviour:
- Reset: state=IDLE; sel_ready, ccff_head, ccff_en, busy, done, err_range all 0; slot counter, bit counter and shift register cleared. Reset mid-operation aborts immediately with no further ccff_en pulses. A partially shifted chain is left as-is; software reloads it.
- FSM IDLE -> LOAD -> ENCODE -> SHIFT -> DONE -> IDLE:
  - IDLE: start=1 -> LOAD; slot=0; err_range cleared in the same edge.
  - LOAD: sel_ready=1. A beat transfers on sel_valid&sel_ready and is stored in slot[slot], then slot increments. On the NUM_MUX-th transfer -> ENCODE, with sel_ready=0 from the next cycle. No timeout; stays in LOAD while sel_valid=0.
  - ENCODE (1 cycle): builds a TOTAL-bit shift register from the stored slots -> SHIFT; bitcnt=0.
  - SHIFT: ccff_en=1 and ccff_head=shreg MSB each cycle; shreg shifts left one bit per cycle. After exactly TOTAL cycles with ccff_en=1 -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- start outside IDLE is ignored, with no queuing.
- sel_valid outside LOAD is ignored, and no beat transfers.
- Encoding per mux with index s:
  - mem[0..L1_SIZE-1] = one-hot at position s mod L1_SIZE.
  - mem[L1_SIZE..MEM_BITS-1] = one-hot at position L1_SIZE + (s div L1_SIZE).
  - Exactly two bits set per legal s.
  - If s >= L1_SIZE*L2_SIZE: mem = all zeros (mux disconnected) and err_range sets at the accept edge. err_range holds through DONE until the next accepted start.
- Serial order: mux NUM_MUX-1 first, mux 0 last. Within a mux, mem[MEM_BITS-1] first, mem[0] last.
- Latency with sel_valid held high, start accepted at edge 0:
  - Beats accepted at edges 1..NUM_MUX.
  - ENCODE occupies cycle NUM_MUX+1.
  - ccff_en is high for cycles NUM_MUX+2 .. NUM_MUX+1+TOTAL.
  - done is high in cycle NUM_MUX+2+TOTAL.
  - With defaults: ccff_en in cycles 6..33, done in cycle 34.
- ccff_en and ccff_head are registered outputs. ccff_en is never high outside SHIFT.

Test Plan:
- Reset-state check: assert prog_reset 2 cycles with random inputs -> all outputs 0. start then 4 beats {5,0,11,7} -> ccff_en high exactly 28 consecutive cycles.
- Same load {5,0,11,7} -> ccff_head sequence, capturing the 4 groups mux3 first and each group mem[6]..mem[0]:
  - mux3 sel 7 -> 0100010
  - mux2 sel 11 -> 1000100
  - mux1 sel 0 -> 0001001
  - mux0 sel 5 -> 0010100
  - Also: done pulses once, cycle 34 after start; err_range=0.
- Out-of-range: beats {12,3,15,0} -> err_range=1 from the first accept edge. Mux0 and mux2 groups shift as 0000000; mux1 (sel 3) -> 0010001. err_range stays 1 after done and clears on the next accepted start.
- Handshake: sel_valid toggled 1-0-1-0… -> exactly 4 transfers, ENCODE one cycle after the 4th. start pulses during LOAD/SHIFT are ignored (ccff_en count still 28). sel_ready=0 outside LOAD.
- Reset mid-SHIFT, at the 10th ccff_en cycle -> next cycle busy=0, ccff_en=0, done never pulses. A fresh load afterwards completes normally with 28 shifts.
- Parameter sweep NUM_MUX=1, L1_SIZE=2, L2_SIZE=2 (TOTAL=4, SEL_W=2): sel 3 -> head sequence 1010, done cycle 7 after start.

Source files
------------

// File: rtl/mux_cfg_loader.sv
// -----------------------------------------------------------------------------
// mux_cfg_loader
//
// Configuration sequencer for two-level transmission-gate routing muxes.
// Collects one binary select index per mux over a valid/ready stream, encodes
// each index into the two one-hot mem fields the mux needs (first level of
// L1_SIZE gates, second level of L2_SIZE gates) and shifts the whole frame
// serially into the configuration flip-flop chain. The chain cells generate
// mem_inv themselves; this block only drives ccff_head/ccff_en.
//
// Ports:
//   prog_clk    in   programming clock, all logic on its rising edge
//   prog_reset  in   synchronous, active-high reset
//   start       in   single-cycle load request, honoured only when idle
//   sel_valid   in   select beat valid
//   sel_ready   out  block can accept a select beat (high only while loading)
//   sel_data    in   select index for the next mux, mux 0 first
//   ccff_head   out  serial configuration bit into the chain (registered)
//   ccff_en     out  chain shift enable (registered)
//   busy        out  high whenever the sequencer is not idle
//   done        out  one-cycle pulse once the frame is fully shifted
//   err_range   out  sticky: an out-of-range select was accepted this load
//
// Serial order: mux NUM_MUX-1 first, mux 0 last; within a mux mem[MEM_BITS-1]
// first, mem[0] last. An out-of-range select encodes as all zeros, which leaves
// that mux disconnected.
// -----------------------------------------------------------------------------
module mux_cfg_loader #(
   parameter  int NUM_MUX  = 4,
   parameter  int L1_SIZE  = 3,
   parameter  int L2_SIZE  = 4,
   localparam int MEM_BITS = L1_SIZE + L2_SIZE,
   localparam int TOTAL    = NUM_MUX * MEM_BITS,
   localparam int NUM_SEL  = L1_SIZE * L2_SIZE,
   localparam int SEL_W    = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
   input  logic             prog_clk,
   input  logic             prog_reset,
   input  logic             start,
   input  logic             sel_valid,
   output logic             sel_ready,
   input  logic [SEL_W-1:0] sel_data,
   output logic             ccff_head,
   output logic             ccff_en,
   output logic             busy,
   output logic             done,
   output logic             err_range
);

   // Slot counter must be able to hold NUM_MUX; bit counter covers 0..TOTAL-1.
   localparam int CNT_W = $clog2(NUM_MUX + 1);
   localparam int BIT_W = $clog2(TOTAL + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_ENCODE = 3'd2;
   localparam logic [2:0] S_SHIFT  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]       state_q,     state_d;
   logic [CNT_W-1:0] slot_cnt_q,  slot_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [TOTAL-1:0] shreg_q,     shreg_d;
   logic             ccff_en_q,   ccff_en_d;
   logic             ccff_head_q, ccff_head_d;
   logic             err_range_q, err_range_d;
   logic [SEL_W-1:0] slots_q [NUM_MUX];
   logic [SEL_W-1:0] slots_d [NUM_MUX];
   logic [TOTAL-1:0] frame;

   // One mux worth of mem bits: low field one-hot at s mod L1_SIZE, high field
   // one-hot at s div L1_SIZE. Illegal indices give all zeros.
   function automatic logic [MEM_BITS-1:0] encode_sel(input logic [SEL_W-1:0] sel);
      logic [MEM_BITS-1:0] mem;
      int                  s;
      mem = '0;
      s   = int'(sel);
      if (s < NUM_SEL) begin
         for (int j = 0; j < MEM_BITS; j++) begin
            if (j < L1_SIZE) mem[j] = (s % L1_SIZE == j);
            else             mem[j] = (s / L1_SIZE == j - L1_SIZE);
         end
      end
      return mem;
   endfunction

   // Mux m occupies frame[m*MEM_BITS +: MEM_BITS], so the frame MSB is
   // mem[MEM_BITS-1] of the last mux, which is the first bit on the wire.
   always_comb begin
      frame = '0;
      for (int m = 0; m < NUM_MUX; m++) begin
         frame[m*MEM_BITS +: MEM_BITS] = encode_sel(slots_q[m]);
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d     = state_q;
      slot_cnt_d  = slot_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ccff_en_d   = 1'b0;
      ccff_head_d = 1'b0;
      err_range_d = err_range_q;
      slots_d     = slots_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               slot_cnt_d  = '0;
               err_range_d = 1'b0;
            end
         end

         S_LOAD: begin
            // sel_ready is high throughout LOAD, so sel_valid alone is a transfer.
            if (sel_valid) begin
               for (int i = 0; i < NUM_MUX; i++) begin
                  if (slot_cnt_q == CNT_W'(i)) slots_d[i] = sel_data;
               end
               if (int'(sel_data) >= NUM_SEL) err_range_d = 1'b1;
               slot_cnt_d = slot_cnt_q + 1'b1;
               if (slot_cnt_q == CNT_W'(NUM_MUX - 1)) state_d = S_ENCODE;
            end
         end

         S_ENCODE: begin
            // The first bit goes straight to the output flop, so the shift
            // register is loaded already advanced by one position.
            ccff_en_d   = 1'b1;
            ccff_head_d = frame[TOTAL-1];
            shreg_d     = frame << 1;
            bit_cnt_d   = '0;
            state_d     = S_SHIFT;
         end

         S_SHIFT: begin
            // bit_cnt_q counts the cycle currently presenting ccff_en=1.
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(TOTAL - 1)) begin
               state_d = S_DONE;
            end else begin
               ccff_en_d   = 1'b1;
               ccff_head_d = shreg_q[TOTAL-1];
               shreg_d     = shreg_q << 1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q     <= S_IDLE;
         slot_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         ccff_en_q   <= 1'b0;
         ccff_head_q <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_cnt_q  <= slot_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         ccff_en_q   <= ccff_en_d;
         ccff_head_q <= ccff_head_d;
         err_range_q <= err_range_d;
      end
   end

   // NOTE: the slot storage is deliberately not reset; every slot is written
   // in LOAD before ENCODE reads it, so a reset would only cost routing.
   always_ff @(posedge prog_clk) begin
      slots_q <= slots_d;
   end

   assign sel_ready = (state_q == S_LOAD);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign ccff_en   = ccff_en_q;
   assign ccff_head = ccff_head_q;
   assign err_range = err_range_q;

endmodule

// File: tb/tb_mux_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_mux_cfg_loader
//
// Self-checking bench for mux_cfg_loader. A table of loads with hand-derived
// serial streams, hand-written reset and abort sequences, randomized loads
// against a serial-stream reference model, and a small-parameter instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mux_cfg_loader;

   localparam int NUM_MUX = 4;
   localparam int L1      = 3;
   localparam int L2      = 4;
   localparam int MEMB    = L1 + L2;
   localparam int TOTAL   = NUM_MUX * MEMB;

   logic       prog_clk   = 1'b0;
   logic       prog_reset = 1'b1;
   logic       start      = 1'b0;
   logic       sel_valid  = 1'b0;
   logic [3:0] sel_data   = '0;
   logic       sel_ready, ccff_head, ccff_en, busy, done, err_range;

   logic       sm_start = 1'b0;
   logic       sm_valid = 1'b0;
   logic [1:0] sm_data  = '0;
   logic       sm_ready, sm_head, sm_en, sm_busy, sm_done, sm_err;

   int checks = 0;
   int errors = 0;

   always #5 prog_clk = ~prog_clk;

   mux_cfg_loader u_dut (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .start      (start),
      .sel_valid  (sel_valid),
      .sel_ready  (sel_ready),
      .sel_data   (sel_data),
      .ccff_head  (ccff_head),
      .ccff_en    (ccff_en),
      .busy       (busy),
      .done       (done),
      .err_range  (err_range)
   );

   mux_cfg_loader #(.NUM_MUX(1), .L1_SIZE(2), .L2_SIZE(2)) u_small (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .start      (sm_start),
      .sel_valid  (sm_valid),
      .sel_ready  (sm_ready),
      .sel_data   (sm_data),
      .ccff_head  (sm_head),
      .ccff_en    (sm_en),
      .busy       (sm_busy),
      .done       (sm_done),
      .err_range  (sm_err)
   );

   typedef struct packed {
      logic [15:0]      sels;   // nibble i = select for mux i
      int               vmode;  // 0 valid held, 1 alternating, 2 random
      bit               poke;   // extra start pulses during LOAD/SHIFT
      logic [TOTAL-1:0] stream; // expected ccff_head bits, first bit at MSB
      bit               err;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: walk the wire order (last mux first, top mem bit first) and
   // decide each bit from the mux's select with plain arithmetic.
   function automatic logic [TOTAL-1:0] ref_stream(input logic [15:0] sels);
      bit               q [$];
      logic [TOTAL-1:0] r;
      logic [15:0]      t;
      int               s;
      for (int m = NUM_MUX - 1; m >= 0; m--) begin
         t = sels >> (4 * m);
         s = int'(t[3:0]);
         for (int j = MEMB - 1; j >= 0; j--) begin
            if (s >= L1 * L2)  q.push_back(1'b0);
            else if (j >= L1)  q.push_back(j - L1 == s / L1);
            else               q.push_back(j == s % L1);
         end
      end
      r = '0;
      foreach (q[k]) r = {r[TOTAL-2:0], q[k]};
      return r;
   endfunction

   function automatic bit any_oor(input logic [15:0] sels);
      logic [15:0] t;
      bit          e;
      e = 1'b0;
      for (int m = 0; m < NUM_MUX; m++) begin
         t = sels >> (4 * m);
         if (int'(t[3:0]) >= L1 * L2) e = 1'b1;
      end
      return e;
   endfunction

   // One full load. rst_at_en > 0 pulses prog_reset during that ccff_en cycle.
   task automatic run_load(input string tag, input logic [15:0] sels, input int vmode,
                           input bit poke, input int rst_at_en,
                           input logic [TOTAL-1:0] exp_stream, input bit exp_err);
      int               xfers = 0;
      int               acc_e = 0;
      int               en_cnt = 0;
      int               first_en = -1;
      int               last_en = -1;
      int               done_cnt = 0;
      int               done_cyc = -1;
      int               abort_cyc = -1;
      int               bad_en = 0, bad_done = 0, bad_busy = 0, bad_rdy = 0, bad_err = 0;
      bit               err_model = 1'b0;
      bit               aborted = 1'b0;
      bit               finished = 1'b0;
      bit               exp_en, exp_done, exp_busy, exp_rdy;
      logic [TOTAL-1:0] got = '0;
      logic [15:0]      t;

      @(negedge prog_clk);
      start     = 1'b1;
      sel_valid = 1'b0;
      for (int c = 1; c <= 400 && !finished; c++) begin
         @(negedge prog_clk);
         start = 1'b0;
         if (aborted) begin
            exp_en = 0; exp_done = 0; exp_busy = 0; exp_rdy = 0;
         end else begin
            exp_rdy  = (xfers < NUM_MUX);
            exp_busy = (acc_e == 0) || (c <= acc_e + 2 + TOTAL);
            exp_en   = (acc_e > 0) && (c >= acc_e + 2) && (c <= acc_e + 1 + TOTAL);
            exp_done = (acc_e > 0) && (c == acc_e + 2 + TOTAL);
         end
         if (c == abort_cyc) begin
            check({tag, "_rst_busy"}, busy, 0);
            check({tag, "_rst_en"}, ccff_en, 0);
            prog_reset = 1'b0;
         end
         if (ccff_en   !== exp_en)    bad_en++;
         if (done      !== exp_done)  bad_done++;
         if (busy      !== exp_busy)  bad_busy++;
         if (sel_ready !== exp_rdy)   bad_rdy++;
         if (err_range !== err_model) bad_err++;
         if (ccff_en === 1'b1) begin
            en_cnt++;
            got = {got[TOTAL-2:0], ccff_head};
            if (first_en < 0) first_en = c;
            last_en = c;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = c;
         end
         if (!aborted && rst_at_en > 0 && ccff_en === 1'b1 && en_cnt == rst_at_en) begin
            prog_reset = 1'b1;
            aborted    = 1'b1;
            abort_cyc  = c + 1;
            err_model  = 1'b0;
         end

         // Drive for the coming rising edge.
         if (vmode == 0)      sel_valid = 1'b1;
         else if (vmode == 1) sel_valid = (c % 2 == 1);
         else                 sel_valid = 1'($urandom_range(0, 1));
         t = sels >> (4 * xfers);
         sel_data = (xfers < NUM_MUX) ? t[3:0] : 4'($urandom);
         start = poke && (c == 2 || (acc_e > 0 && c == acc_e + 10));
         if (sel_valid && sel_ready && !aborted) begin
            xfers++;
            if (int'(sel_data) >= L1 * L2) err_model = 1'b1;
            if (xfers == NUM_MUX) acc_e = c;
         end
         if (!aborted && acc_e > 0 && c >= acc_e + TOTAL + 4) finished = 1'b1;
         if (aborted && c >= abort_cyc + 40) finished = 1'b1;
      end
      start     = 1'b0;
      sel_valid = 1'b0;

      check({tag, "_finished"}, finished, 1);
      if (rst_at_en > 0) begin
         check({tag, "_en_cnt"}, en_cnt, rst_at_en);
         check({tag, "_done_cnt"}, done_cnt, 0);
      end else begin
         check({tag, "_xfers"}, xfers, NUM_MUX);
         check({tag, "_en_cnt"}, en_cnt, TOTAL);
         check({tag, "_en_contig"}, last_en - first_en + 1, TOTAL);
         check({tag, "_first_en"}, first_en, acc_e + 2);
         check({tag, "_done_cnt"}, done_cnt, 1);
         check({tag, "_done_cyc"}, done_cyc, acc_e + 2 + TOTAL);
         check({tag, "_stream"}, got, exp_stream);
         check({tag, "_err_after_done"}, err_range, exp_err);
      end
      check({tag, "_en_trace"}, bad_en, 0);
      check({tag, "_done_trace"}, bad_done, 0);
      check({tag, "_busy_trace"}, bad_busy, 0);
      check({tag, "_ready_trace"}, bad_rdy, 0);
      check({tag, "_err_trace"}, bad_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rs;
      int          sm_en_cnt;
      int          sm_done_cyc;
      logic [3:0]  sm_got;

      vecs[0] = '{16'h7B05, 0, 1'b0, 28'b0100010_1000100_0001001_0010100, 1'b0};
      vecs[1] = '{16'h0F3C, 0, 1'b0, 28'b0001001_0000000_0010001_0000000, 1'b1};
      vecs[2] = '{16'h7B05, 1, 1'b1, 28'b0100010_1000100_0001001_0010100, 1'b0};
      vecs[3] = '{16'h0000, 2, 1'b0, 28'b0001001_0001001_0001001_0001001, 1'b0};
      vecs[4] = '{16'hBBBB, 0, 1'b1, 28'b1000100_1000100_1000100_1000100, 1'b0};

      // Reset with random inputs on the pins.
      prog_reset = 1'b1;
      repeat (2) begin
         @(negedge prog_clk);
         start     = 1'($urandom);
         sel_valid = 1'($urandom);
         sel_data  = 4'($urandom);
      end
      @(negedge prog_clk);
      check("rst_sel_ready", sel_ready, 0);
      check("rst_ccff_head", ccff_head, 0);
      check("rst_ccff_en",   ccff_en,   0);
      check("rst_busy",      busy,      0);
      check("rst_done",      done,      0);
      check("rst_err_range", err_range, 0);
      prog_reset = 1'b0;
      start      = 1'b0;
      sel_valid  = 1'b0;
      @(negedge prog_clk);

      for (int i = 0; i < 5; i++) begin
         run_load($sformatf("v%0d", i), vecs[i].sels, vecs[i].vmode, vecs[i].poke, 0,
                  vecs[i].stream, vecs[i].err);
      end

      // Abort in the 10th shift cycle, then a fresh load must complete.
      run_load("abort", 16'h7B05, 0, 1'b0, 10, '0, 1'b0);
      run_load("reload", vecs[0].sels, 0, 1'b0, 0, vecs[0].stream, 1'b0);

      for (int i = 0; i < 12; i++) begin
         rs = 16'($urandom);
         run_load($sformatf("rnd%0d", i), rs, int'($urandom_range(0, 2)),
                  1'($urandom), 0, ref_stream(rs), any_oor(rs));
      end

      // Small instance: one mux, 2x2, select 3.
      sm_en_cnt   = 0;
      sm_done_cyc = -1;
      sm_got      = '0;
      @(negedge prog_clk);
      sm_start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge prog_clk);
         sm_start = 1'b0;
         if (sm_en === 1'b1) begin
            sm_en_cnt++;
            sm_got = {sm_got[2:0], sm_head};
         end
         if (sm_done === 1'b1) sm_done_cyc = c;
         sm_valid = (c == 1);
         sm_data  = 2'd3;
      end
      sm_valid = 1'b0;
      check("small_en_cnt",   sm_en_cnt,   4);
      check("small_stream",   sm_got,      4'b1010);
      check("small_done_cyc", sm_done_cyc, 7);
      check("small_err",      sm_err,      0);
      check("small_busy_end", sm_busy,     0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
